// File: rtl/vga_pkg.sv
// Shared raster timing constants (640x480 @ 60 Hz defaults) for the timing generator
// and downstream pixel stages.
package vga_pkg;

  localparam int CNT_W  = 10;
  localparam int COL_W  = 10;
  localparam int ROW_W  = 9;
  localparam int FCNT_W = 8;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  function automatic int axis_total(int vis, int fp, int sync, int bp);
    return vis + fp + sync + bp;
  endfunction

  localparam int H_TOTAL      = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL      = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with visible/sync flags registered from
// the counter next-state so they line up with cnt exactly.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL,
  parameter int VIS        = H_VISIBLE,
  parameter int SYNC_START = H_SYNC_START,
  parameter int SYNC_END   = H_SYNC_END
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             vis,
  output logic             sync_n
);

  localparam logic [CNT_W-1:0] L_LAST   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] L_VIS    = CNT_W'(VIS);
  localparam logic [CNT_W-1:0] L_SYNC_S = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] L_SYNC_E = CNT_W'(SYNC_END);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nxt;
  logic             r_vis;
  logic             r_sync_n;
  logic             w_wrap;

  // wrap is combinational: it tells the next axis that this edge rolls over
  assign w_wrap = (r_cnt == L_LAST);

  always_comb begin
    w_nxt = r_cnt;
    if (adv) w_nxt = w_wrap ? '0 : r_cnt + CNT_W'(1);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_cnt    <= L_LAST;
      r_vis    <= 1'b0;
      r_sync_n <= 1'b1;
    end else if (adv) begin
      r_cnt    <= w_nxt;
      r_vis    <= (w_nxt < L_VIS);
      r_sync_n <= !((w_nxt >= L_SYNC_S) && (w_nxt < L_SYNC_E));
    end
  end

  assign cnt    = r_cnt;
  assign wrap   = w_wrap;
  assign vis    = r_vis;
  assign sync_n = r_sync_n;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, active-low syncs, display enable, frame strobe.
// Optional frame counter built only when VGA_FRAME_COUNT_EN is defined.
module vga_timing_gen #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] col,
  output logic [8:0] row,
  output logic       active,
  output logic       h_sync,
  output logic       v_sync,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  import vga_pkg::*;

  localparam int L_H_TOTAL = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int L_V_TOTAL = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
  logic             w_h_wrap, w_v_wrap;
  logic             w_h_vis, w_v_vis;
  logic             w_h_sync_n, w_v_sync_n;
  logic             w_v_adv;
  logic             w_frame_edge;
  logic             w_unused_v_msb;
  logic             r_frame_start;

  assign w_v_adv      = pix_en & w_h_wrap;
  assign w_frame_edge = pix_en & w_h_wrap & w_v_wrap;

  vga_axis_counter #(
    .TOTAL      (L_H_TOTAL),
    .VIS        (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FP),
    .SYNC_END   (H_VISIBLE + H_FP + H_SYNC)
  ) u_h (
    .vga_clk (vga_clk),
    .reset   (reset),
    .adv     (pix_en),
    .cnt     (w_h_cnt),
    .wrap    (w_h_wrap),
    .vis     (w_h_vis),
    .sync_n  (w_h_sync_n)
  );

  vga_axis_counter #(
    .TOTAL      (L_V_TOTAL),
    .VIS        (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FP),
    .SYNC_END   (V_VISIBLE + V_FP + V_SYNC)
  ) u_v (
    .vga_clk (vga_clk),
    .reset   (reset),
    .adv     (w_v_adv),
    .cnt     (w_v_cnt),
    .wrap    (w_v_wrap),
    .vis     (w_v_vis),
    .sync_n  (w_v_sync_n)
  );

  // Edge that lands on (0,0); held across pix_en=0 so it spans one pixel period
  always_ff @(posedge vga_clk) begin
    if (reset)       r_frame_start <= 1'b0;
    else if (pix_en) r_frame_start <= w_h_wrap & w_v_wrap;
  end

  // Row only needs 9 bits once clamped to the visible area
  assign w_unused_v_msb = w_v_cnt[CNT_W-1];

  assign active      = w_h_vis & w_v_vis;
  assign col         = active ? w_h_cnt[COL_W-1:0] : '0;
  assign row         = active ? w_v_cnt[ROW_W-1:0] : '0;
  assign h_sync      = w_h_sync_n;
  assign v_sync      = w_v_sync_n;
  assign frame_start = r_frame_start;

`ifdef VGA_FRAME_COUNT_EN
  logic [FCNT_W-1:0] r_frame_cnt;

  always_ff @(posedge vga_clk) begin
    if (reset)             r_frame_cnt <= '0;
    else if (w_frame_edge) r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
  end

  assign frame_cnt = r_frame_cnt;
`else
  logic w_unused_frame_edge;
  assign w_unused_frame_edge = w_frame_edge;
  assign frame_cnt           = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line-level checks, a tiny-timing instance
// (16x10 raster) for whole-frame and frame-counter checks.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_en;

  logic [9:0] col,   col_s;
  logic [8:0] row,   row_s;
  logic       active, active_s;
  logic       h_sync, h_sync_s;
  logic       v_sync, v_sync_s;
  logic       fs,    fs_s;
  logic [7:0] fc,    fc_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .vga_clk(clk), .reset(reset), .pix_en(pix_en),
    .col(col), .row(row), .active(active), .h_sync(h_sync), .v_sync(v_sync),
    .frame_start(fs), .frame_cnt(fc)
  );

  // 16 x 10 raster: H 8/2/3/3 (sync 10..12), V 6/1/2/1 (sync 7..8), 160 pixels per frame
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .vga_clk(clk), .reset(reset), .pix_en(pix_en),
    .col(col_s), .row(row_s), .active(active_s), .h_sync(h_sync_s), .v_sync(v_sync_s),
    .frame_start(fs_s), .frame_cnt(fc_s)
  );

`ifdef VGA_FRAME_COUNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [22:0] got, exp;
    reset = 1'b1; pix_en = 1'b1;
    repeat (4) tick();
    got = {col, row, active, h_sync, v_sync, fs};
    exp = {10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_outputs: got %h exp %h", got, exp); end
    n_cmp++;
    if (fc !== 8'd0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d exp 0", fc); end
    reset = 1'b0;
    tick();
    got = {col, row, active, h_sync, v_sync, fs};
    exp = {10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL first_edge: got %h exp %h", got, exp); end
  endtask

  // Starts at (0,0) right after test_reset
  task automatic test_line();
    int hs_low = 0, first_hs = -1, act = 0, bad_col = 0, fs_n = 0, vs_low = 0;
    for (int i = 0; i < 800; i++) begin
      if (!h_sync) begin hs_low++; if (first_hs < 0) first_hs = i; end
      if (active) act++;
      if (active && col !== 10'(i)) bad_col++;
      if (fs) fs_n++;
      if (!v_sync) vs_low++;
      tick();
    end
    n_cmp++;
    if (hs_low !== 96) begin n_err++; $display("FAIL hsync_width: got %0d exp 96", hs_low); end
    n_cmp++;
    if (first_hs !== 656) begin n_err++; $display("FAIL hsync_start: got %0d exp 656", first_hs); end
    n_cmp++;
    if (act !== 640) begin n_err++; $display("FAIL active_width: got %0d exp 640", act); end
    n_cmp++;
    if (bad_col !== 0) begin n_err++; $display("FAIL col_sweep: got %0d bad exp 0", bad_col); end
    n_cmp++;
    if (fs_n !== 1 || vs_low !== 0) begin
      n_err++; $display("FAIL line_fs_vs: got fs=%0d vs_low=%0d exp 1 0", fs_n, vs_low);
    end
    n_cmp++;
    if ({col, row, active} !== {10'd0, 9'd1, 1'b1}) begin
      n_err++; $display("FAIL row_advance: got col=%0d row=%0d act=%b exp 0 1 1", col, row, active);
    end
  endtask

  task automatic test_pix_en_toggle();
    bit   pe  [9] = '{0, 1, 0, 0, 1, 0, 1, 0, 1};
    int   ecol[9] = '{0, 0, 0, 0, 1, 1, 2, 2, 3};
    bit   efs [9] = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
    bit   eact[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    reset = 1'b1; pix_en = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      pix_en = pe[k];
      tick();
      n_cmp++;
      if ({col, fs, active, h_sync} !== {10'(ecol[k]), efs[k], eact[k], 1'b1}) begin
        n_err++;
        $display("FAIL toggle_step%0d: got col=%0d fs=%b act=%b hs=%b exp col=%0d fs=%b act=%b hs=1",
                 k, col, fs, active, h_sync, ecol[k], efs[k], eact[k]);
      end
    end
    pix_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    reset = 1'b1; pix_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    repeat (53) tick();
    n_cmp++;
    if ({col_s, row_s, active_s} !== {10'd5, 9'd3, 1'b1}) begin
      n_err++; $display("FAIL small_pos53: got col=%0d row=%0d act=%b exp 5 3 1", col_s, row_s, active_s);
    end
    repeat (247) tick();
    // default at (300,0); small at pixel 140 = (12,8), inside both sync pulses
    n_cmp++;
    if ({col, row, h_sync_s, v_sync_s, active_s} !== {10'd300, 9'd0, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL pre_reset: got col=%0d row=%0d hs_s=%b vs_s=%b act_s=%b exp 300 0 0 0 0",
                        col, row, h_sync_s, v_sync_s, active_s);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({col, active, h_sync, v_sync, fs, col_s, active_s, h_sync_s, v_sync_s, fs_s} !==
        {10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL mid_reset: got col=%0d act=%b fs=%b hs_s=%b vs_s=%b exp 0 0 0 1 1",
                        col, active, fs, h_sync_s, v_sync_s);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({col, row, active, fs, col_s, row_s, fs_s} !== {10'd0, 9'd0, 1'b1, 1'b1, 10'd0, 9'd0, 1'b1}) begin
      n_err++; $display("FAIL post_reset: got col=%0d row=%0d act=%b fs=%b fs_s=%b exp 0 0 1 1 1",
                        col, row, active, fs, fs_s);
    end
  endtask

  task automatic test_full_frame();
    int hs_low = 0, vs_low = 0, first_vs = -1, vs_rise = -1, act = 0, fs_n = 0, bad = 0;
    bit prev_vs = 1'b1;
    int h, v;
    bit ea;
    reset = 1'b1; pix_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 160; i++) begin
      h  = i % 16;
      v  = i / 16;
      ea = (h < 8) && (v < 6);
      if ({col_s, row_s, active_s} !== {ea ? 10'(h) : 10'd0, ea ? 9'(v) : 9'd0, ea}) bad++;
      if (!h_sync_s) hs_low++;
      if (!v_sync_s) begin vs_low++; if (first_vs < 0) first_vs = i; end
      if (v_sync_s && !prev_vs) vs_rise = i;
      prev_vs = v_sync_s;
      if (active_s) act++;
      if (fs_s) fs_n++;
      tick();
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL frame_pixels: got %0d bad exp 0", bad); end
    n_cmp++;
    if (hs_low !== 30 || act !== 48) begin
      n_err++; $display("FAIL frame_hs_act: got hs_low=%0d act=%0d exp 30 48", hs_low, act);
    end
    n_cmp++;
    if (vs_low !== 32 || first_vs !== 112 || vs_rise !== 144) begin
      n_err++; $display("FAIL vsync_window: got low=%0d first=%0d rise=%0d exp 32 112 144",
                        vs_low, first_vs, vs_rise);
    end
    n_cmp++;
    if (fs_n !== 1) begin n_err++; $display("FAIL fs_per_frame: got %0d exp 1", fs_n); end
    n_cmp++;
    if ({col_s, row_s, active_s, fs_s} !== {10'd0, 9'd0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL frame_wrap: got col=%0d row=%0d act=%b fs=%b exp 0 0 1 1",
                        col_s, row_s, active_s, fs_s);
    end
    n_cmp++;
    if (fc_s !== (FC_EN ? 8'd2 : 8'd0)) begin
      n_err++; $display("FAIL frame_cnt_2: got %0d exp %0d", fc_s, FC_EN ? 2 : 0);
    end
  endtask

  task automatic test_frame_cnt_wrap();
    reset = 1'b1; pix_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (fc_s !== (FC_EN ? 8'd1 : 8'd0)) begin
      n_err++; $display("FAIL fc_first: got %0d exp %0d", fc_s, FC_EN ? 1 : 0);
    end
    repeat (254 * 160) tick();
    n_cmp++;
    if (fc_s !== (FC_EN ? 8'd255 : 8'd0) || fs_s !== 1'b1) begin
      n_err++; $display("FAIL fc_255: got %0d fs=%b exp %0d fs=1", fc_s, fs_s, FC_EN ? 255 : 0);
    end
    repeat (160) tick();
    n_cmp++;
    if (fc_s !== 8'd0) begin n_err++; $display("FAIL fc_wrap0: got %0d exp 0", fc_s); end
    repeat (160) tick();
    n_cmp++;
    if (fc_s !== (FC_EN ? 8'd1 : 8'd0) || fs_s !== 1'b1) begin
      n_err++; $display("FAIL fc_257: got %0d fs=%b exp %0d fs=1", fc_s, fs_s, FC_EN ? 1 : 0);
    end
  endtask

  initial begin
    reset  = 1'b1;
    pix_en = 1'b0;
    test_reset();
    test_line();
    test_pix_en_toggle();
    test_reset_mid_frame();
    test_full_frame();
    test_frame_cnt_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
